var_delay_buffer: RTL and testbench

VAR_DELAY_BUFFER -- requirements
Module: var_delay_buffer

---
 rtl/var_delay_buffer.sv | 152 +++++++++++++++
 tb/tb_var_delay_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/var_delay_buffer.sv
// Programmable delay line: data_out repeats data_in from (depth_q-1) enabled pushes earlier.
// Define BUFFER_VALID_EN to add in_valid/out_valid, delayed alongside the data.
module var_delay_buffer #(
   parameter int  NB        = 32,
   parameter int  MAX_DEPTH = 16,
   localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          depth_ld,
   input  logic [DW-1:0] depth,
   input  logic [NB-1:0] data_in,
   output logic [NB-1:0] data_out,
   output logic          primed
`ifdef BUFFER_VALID_EN
   ,
   input  logic          in_valid,
   output logic          out_valid
`endif
);

   localparam int PW = $clog2(MAX_DEPTH);

   logic [NB-1:0] mem [MAX_DEPTH];

   logic [DW-1:0] depth_q, depth_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic          primed_q, primed_d;
   logic [NB-1:0] data_out_q, data_out_d;

   logic [DW-1:0] depth_clamped;
   logic [PW-1:0] lag;
   logic [PW-1:0] rd_idx;
   logic [PW-1:0] ptr_inc;
   logic [DW-1:0] cnt_inc;
   logic          push;
   logic          fill_done;
   logic [NB-1:0] rd_word;

   assign push = en & ~depth_ld;

   always_comb begin
      depth_clamped = depth;
      if (depth == '0) begin
         depth_clamped = DW'(1);
      end else if (depth > DW'(MAX_DEPTH)) begin
         depth_clamped = DW'(MAX_DEPTH);
      end
   end

   // Oldest word still needed sits (depth_q-1) slots behind the write pointer, modulo MAX_DEPTH.
   // For power-of-two MAX_DEPTH the PW-bit cast of MAX_DEPTH is 0, which wraps correctly.
   always_comb begin
      lag = PW'(depth_q - DW'(1));
      if (wr_ptr_q >= lag) begin
         rd_idx = wr_ptr_q - lag;
      end else begin
         rd_idx = wr_ptr_q + (PW'(MAX_DEPTH) - lag);
      end
   end

   assign ptr_inc = (wr_ptr_q == PW'(MAX_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
   assign cnt_inc = (cnt_q < depth_q) ? cnt_q + DW'(1) : cnt_q;
   assign fill_done = primed_q | (cnt_inc == depth_q);

   // A lag of zero means the word being pushed right now, which is not yet in the array.
   assign rd_word = (depth_q == DW'(1)) ? data_in : mem[rd_idx];

   always_comb begin
      depth_d    = depth_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      primed_d   = primed_q;
      data_out_d = data_out_q;
      if (depth_ld) begin
         depth_d    = depth_clamped;
         cnt_d      = '0;
         wr_ptr_d   = '0;
         primed_d   = 1'b0;
         data_out_d = '0;
      end else if (en) begin
         wr_ptr_d   = ptr_inc;
         cnt_d      = cnt_inc;
         primed_d   = fill_done;
         data_out_d = fill_done ? rd_word : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_q    <= DW'(MAX_DEPTH);
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         primed_q   <= 1'b0;
         data_out_q <= '0;
      end else begin
         depth_q    <= depth_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         primed_q   <= primed_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is never reset; stale entries stay masked until primed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   assign data_out = data_out_q;
   assign primed   = primed_q;

`ifdef BUFFER_VALID_EN
   logic [MAX_DEPTH-1:0] vmem;
   logic                 out_valid_q, out_valid_d;
   logic                 rd_valid;

   assign rd_valid = (depth_q == DW'(1)) ? in_valid : vmem[rd_idx];

   always_comb begin
      out_valid_d = out_valid_q;
      if (depth_ld) begin
         out_valid_d = 1'b0;
      end else if (en) begin
         out_valid_d = fill_done & rd_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         vmem[wr_ptr_q] <= in_valid;
      end
   end

   assign out_valid = out_valid_q;
`else
   // Valid tracking absent: no in_valid/out_valid ports and no valid storage.
`endif

endmodule

// File: tb/tb_var_delay_buffer.sv
// Randomized scoreboard bench for var_delay_buffer against a history-queue reference model.
module tb_var_delay_buffer;
   localparam int NB  = 32;
   localparam int MAX = 16;
   localparam int DW  = $clog2(MAX + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          depth_ld = 1'b0;
   logic [DW-1:0] depth = '0;
   logic [NB-1:0] data_in = '0;
   logic [NB-1:0] data_out;
   logic          primed;
`ifdef BUFFER_VALID_EN
   logic          in_valid = 1'b0;
   logic          out_valid;
`endif

   var_delay_buffer #(.NB(NB), .MAX_DEPTH(MAX)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .depth_ld (depth_ld),
      .depth    (depth),
      .data_in  (data_in),
      .data_out (data_out),
      .primed   (primed)
`ifdef BUFFER_VALID_EN
      ,
      .in_valid (in_valid),
      .out_valid(out_valid)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NB-1:0] d;
      logic          p;
      logic          v;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the words pushed since the last load/reset, newest last.
   int            m_depth;
   int            m_pushes;
   logic [NB-1:0] m_hist[$];
   logic          m_vhist[$];
   exp_t          m_out;

   function automatic void model_reset();
      m_depth  = MAX;
      m_pushes = 0;
      m_hist.delete();
      m_vhist.delete();
      m_out = '{d: '0, p: 1'b0, v: 1'b0};
   endfunction

   function automatic void model_load(int req);
      model_reset();
      m_depth = (req < 1) ? 1 : ((req > MAX) ? MAX : req);
   endfunction

   function automatic void model_push(logic [NB-1:0] d, logic v);
      m_hist.push_back(d);
      m_vhist.push_back(v);
      if (m_hist.size() > MAX) begin
         void'(m_hist.pop_front());
         void'(m_vhist.pop_front());
      end
      m_pushes++;
      if (m_pushes >= m_depth) begin
         m_out.d = m_hist[m_hist.size() - m_depth];
         m_out.v = m_vhist[m_vhist.size() - m_depth];
         m_out.p = 1'b1;
      end else begin
         m_out = '{d: '0, p: 1'b0, v: 1'b0};
      end
   endfunction

   task automatic check(string name, logic [NB-1:0] act, logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_zero_outputs(string tag);
      check({tag, ".data_out"}, data_out, '0);
      check({tag, ".primed"}, NB'(primed), '0);
`ifdef BUFFER_VALID_EN
      check({tag, ".out_valid"}, NB'(out_valid), '0);
`endif
   endtask

   // Drive one clock cycle of stimulus and queue the state expected after its rising edge.
   task automatic step(bit e, bit ld, int dep, logic [NB-1:0] d, bit v, bit rst_pulse = 1'b0);
      @(negedge clk);
      en       = e;
      depth_ld = ld;
      depth    = DW'(dep);
      data_in  = d;
`ifdef BUFFER_VALID_EN
      in_valid = v;
`endif
      if (rst_pulse) begin
         #1 rst_n = 1'b0;
         #1 check_zero_outputs("async_reset");
         model_reset();
         #1 rst_n = 1'b1;
      end
      if (ld) begin
         model_load(dep);
      end else if (e) begin
         model_push(d, v);
      end
      sb.push_back(m_out);
   endtask

   // Monitor: every edge that has a queued expectation is compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("data_out", data_out, e.d);
            check("primed", NB'(primed), NB'(e.p));
`ifdef BUFFER_VALID_EN
            check("out_valid", NB'(out_valid), NB'(e.v));
`endif
            $display("edge t=%0t en=%0b ld=%0b din=%0h -> data_out=%0h primed=%0b",
                     $time - 2, en, depth_ld, data_in, data_out, primed);
         end
      end
   end

   initial begin
      model_reset();
      #3 check_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Depth after reset is MAX: sixteen pushes to primed.
      for (int i = 1; i <= 18; i++) step(1, 0, 0, NB'(i), 1'b1);

      // depth=4 with an incrementing stream; load-cycle data is discarded.
      step(0, 1, 4, 32'hDEAD_BEEF, 1'b1);
      for (int i = 1; i <= 6; i++) step(1, 0, 0, NB'(i), (i % 2) == 1);

      // depth=1 degenerates to a plain register.
      step(1, 1, 1, 32'hBAD0_0001, 1'b1);
      for (int i = 0; i < 5; i++) step(1, 0, 0, $urandom, 1'($urandom));

      // depth=0 clamps to 1; depth beyond MAX clamps to MAX.
      step(0, 1, 0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, $urandom, 1'($urandom));
      step(1, 1, MAX + 5, 32'h0, 1'b0);
      for (int i = 0; i < 20; i++) step(1, 0, 0, NB'(200 + i), 1'($urandom));

      // D=3 with en toggling: only enabled edges count.
      step(1, 1, 3, 32'h0, 1'b0);
      for (int i = 0; i < 12; i++) step((i % 2) == 0, 0, 0, NB'(100 + i), 1'b1);

      // Primed at D=8, then reload to 2 with en high: old data must never appear.
      step(1, 1, 8, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, NB'(300 + i), 1'b1);
      step(1, 1, 2, NB'(999), 1'b1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, NB'(400 + i), 1'b1);

      // Short reset pulse mid-stream, then valid pattern 1,0,1,1 followed by filler.
      step(1, 1, 4, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, NB'(500 + i), 1'b1);
      step(1, 0, 0, NB'(600), 1'b1, 1'b1);
      step(1, 0, 0, NB'(601), 1'b0);
      step(1, 0, 0, NB'(602), 1'b1);
      step(1, 0, 0, NB'(603), 1'b1);
      for (int i = 0; i < 16; i++) step(1, 0, 0, NB'(700 + i), 1'b0);

      // Randomized soak.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4, $urandom_range(0, 20),
              $urandom, 1'($urandom), $urandom_range(0, 99) < 1);
      end

      @(negedge clk);
      en       = 1'b0;
      depth_ld = 1'b0;
      for (int k = 0; k < 10 && sb.size() > 0; k++) begin
         @(posedge clk);
         #3;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
